// File: rtl/score_glyph_gen.sv
// Score register with bus-write commands, double-dabble BCD conversion and 4x8 digit glyph output.
// Optional macro SCORE_SATURATE_EN: ADD overflow clamps to MAX_SCORE instead of wrapping.
module score_glyph_gen #(
  parameter int MAX_SCORE = 999
) (
  input  logic        clk,
  input  logic        res,
  input  logic        write_en0,
  input  logic        right_addr,
  input  logic [31:0] pwdata,
  input  logic [1:0]  digit_sel,
  output logic [31:0] data,
  output logic        busy,
  output logic [9:0]  score_bin
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_PACK    = 2'd2
  } state_t;

  localparam logic [10:0] MAX11     = 11'(MAX_SCORE);
  localparam logic [31:0] GLYPH_ZERO = 32'h7555_5557;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [9:0]  r_score;
  logic [9:0]  r_bin;
  logic [11:0] r_bcd;
  logic [31:0] r_data;
  logic        r_busy;

  logic [1:0]  w_cmd;
  logic [10:0] w_opd;
  logic [10:0] w_sum;
  logic [10:0] w_wrap;
  logic [9:0]  w_load_val;
  logic [9:0]  w_add_val;
  logic [9:0]  w_new_score;
  logic [11:0] w_adj;
  logic [3:0]  w_digit;
  logic        w_accept;
  logic        w_unused;

  function automatic logic [11:0] dabble_adj(input logic [11:0] b);
    logic [11:0] o;
    for (int i = 0; i < 3; i++) begin
      o[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? (b[4*i +: 4] + 4'd3) : b[4*i +: 4];
    end
    return o;
  endfunction

  function automatic logic [31:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 32'h7555_5557;
      4'd1:    glyph = 32'h2222_2222;
      4'd2:    glyph = 32'h7111_7447;
      4'd3:    glyph = 32'h7444_7447;
      4'd4:    glyph = 32'h4444_7555;
      4'd5:    glyph = 32'h7444_7117;
      4'd6:    glyph = 32'h7555_7117;
      4'd7:    glyph = 32'h4444_4447;
      4'd8:    glyph = 32'h7555_7557;
      4'd9:    glyph = 32'h7444_7557;
      default: glyph = 32'h0000_0000;
    endcase
  endfunction

  assign w_cmd      = pwdata[31:30];
  assign w_opd      = {1'b0, pwdata[9:0]};
  assign w_unused   = ^pwdata[29:10];
  assign w_accept   = write_en0 & right_addr & ~r_busy & (w_cmd != 2'b11);
  assign w_sum      = {1'b0, r_score} + w_opd;
  assign w_wrap     = w_sum - (MAX11 + 11'd1);
  assign w_load_val = (w_opd > MAX11) ? MAX11[9:0] : w_opd[9:0];
`ifdef SCORE_SATURATE_EN
  assign w_add_val  = (w_sum > MAX11) ? MAX11[9:0] : w_sum[9:0];
`else
  assign w_add_val  = (w_sum > MAX11) ? w_wrap[9:0] : w_sum[9:0];
`endif
  assign w_new_score = (w_cmd == 2'b00) ? w_load_val :
                       (w_cmd == 2'b01) ? w_add_val  : 10'd0;
  assign w_adj      = dabble_adj(r_bcd);
  assign w_digit    = (digit_sel == 2'd0) ? r_bcd[3:0] :
                      (digit_sel == 2'd1) ? r_bcd[7:4] :
                      (digit_sel == 2'd2) ? r_bcd[11:8] : 4'hF;

  // Command decode, conversion sequencing and glyph packing.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_score <= 10'd0;
      r_bin   <= 10'd0;
      r_bcd   <= 12'd0;
      r_data  <= GLYPH_ZERO;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_score <= w_new_score;
            r_bin   <= w_new_score;
            r_bcd   <= 12'd0;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b1;
            r_state <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          r_bcd <= {w_adj[10:0], r_bin[9]};
          r_bin <= {r_bin[8:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd9) begin
            r_state <= ST_PACK;
          end
        end
        ST_PACK: begin
          // digit 15 falls through the font table to a blank glyph
          r_data  <= glyph(w_digit);
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data      = r_data;
  assign busy      = r_busy;
  assign score_bin = r_score;

endmodule

// File: tb/tb_score_glyph_gen.sv
// Directed self-checking bench for score_glyph_gen with hand-computed expectations.
module tb_score_glyph_gen;

  logic        clk = 1'b0;
  logic        res;
  logic        write_en0;
  logic        right_addr;
  logic [31:0] pwdata;
  logic [1:0]  digit_sel;
  logic [31:0] data;
  logic        busy;
  logic [9:0]  score_bin;

  int vectors = 0;
  int miscompares = 0;

  score_glyph_gen #(.MAX_SCORE(999)) dut (
    .clk        (clk),
    .res        (res),
    .write_en0  (write_en0),
    .right_addr (right_addr),
    .pwdata     (pwdata),
    .digit_sel  (digit_sel),
    .data       (data),
    .busy       (busy),
    .score_bin  (score_bin)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the write edge.
  task automatic do_write(input logic [1:0] cmd, input logic [9:0] opd, input logic hit);
    write_en0  = 1'b1;
    right_addr = hit;
    pwdata     = {cmd, 20'd0, opd};
    @(negedge clk);
    write_en0  = 1'b0;
    right_addr = 1'b0;
    pwdata     = 32'd0;
  endtask

  // From just after E0: busy must hold through E10 with data unchanged, then fall at E11.
  task automatic run_conv(input string tag, input logic [31:0] old_data, input logic [31:0] new_data);
    repeat (10) @(negedge clk);
    check({tag, "_busy_e10"}, {31'd0, busy}, 32'd1);
    check({tag, "_hold_e10"}, data, old_data);
    @(negedge clk);
    check({tag, "_busy_e11"}, {31'd0, busy}, 32'd0);
    check({tag, "_data"}, data, new_data);
  endtask

  initial begin
    res = 1'b1; write_en0 = 1'b0; right_addr = 1'b0; pwdata = 32'd0; digit_sel = 2'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_score", {22'd0, score_bin}, 32'd0);
    check("rst_data", data, 32'h7555_5557);
    res = 1'b0;
    @(negedge clk);

    // LOAD 123, tens digit
    digit_sel = 2'd1;
    do_write(2'b00, 10'd123, 1'b1);
    check("load123_score", {22'd0, score_bin}, 32'd123);
    check("load123_busy", {31'd0, busy}, 32'd1);
    run_conv("load123", 32'h7555_5557, 32'h7111_7447);

    // digit_sel changes outside PACK are ignored
    digit_sel = 2'd0;
    repeat (3) @(negedge clk);
    check("dsel_ignored", data, 32'h7111_7447);

    // ADD 5 -> 128, ones digit 8
    do_write(2'b01, 10'd5, 1'b1);
    check("add5_score", {22'd0, score_bin}, 32'd128);
    run_conv("add5", 32'h7111_7447, 32'h7555_7557);

    // LOAD 50, then a CLEAR three cycles later is dropped
    digit_sel = 2'd1;
    do_write(2'b00, 10'd50, 1'b1);
    repeat (2) @(negedge clk);
    do_write(2'b10, 10'd0, 1'b1);
    check("drop_score", {22'd0, score_bin}, 32'd50);
    repeat (7) @(negedge clk);
    check("drop_busy_e10", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("drop_busy_e11", {31'd0, busy}, 32'd0);
    check("drop_data", data, 32'h7444_7117);
    check("drop_score_end", {22'd0, score_bin}, 32'd50);

    // LOAD clamps to 999
    digit_sel = 2'd0;
    do_write(2'b00, 10'd1023, 1'b1);
    check("loadclamp_score", {22'd0, score_bin}, 32'd999);
    run_conv("loadclamp", 32'h7444_7117, 32'h7444_7557);

    // LOAD 990, then ADD 20 overflows
    digit_sel = 2'd1;
    do_write(2'b00, 10'd990, 1'b1);
    check("load990_score", {22'd0, score_bin}, 32'd990);
    run_conv("load990", 32'h7444_7557, 32'h7444_7557);
    do_write(2'b01, 10'd20, 1'b1);
`ifdef SCORE_SATURATE_EN
    check("ovf_score", {22'd0, score_bin}, 32'd999);
    run_conv("ovf", 32'h7444_7557, 32'h7444_7557);
`else
    check("ovf_score", {22'd0, score_bin}, 32'd10);
    run_conv("ovf", 32'h7444_7557, 32'h2222_2222);
`endif

    // CLEAR accepted on E12 (first edge after PACK), blank digit
    digit_sel = 2'd3;
    do_write(2'b10, 10'd77, 1'b1);
    check("clear_score", {22'd0, score_bin}, 32'd0);
    check("clear_busy", {31'd0, busy}, 32'd1);
`ifdef SCORE_SATURATE_EN
    run_conv("clear", 32'h7444_7557, 32'h0000_0000);
`else
    run_conv("clear", 32'h2222_2222, 32'h0000_0000);
`endif

    // Command 11 and address miss have no effect
    do_write(2'b11, 10'd300, 1'b1);
    check("cmd11_busy", {31'd0, busy}, 32'd0);
    check("cmd11_score", {22'd0, score_bin}, 32'd0);
    do_write(2'b00, 10'd7, 1'b0);
    check("miss_busy", {31'd0, busy}, 32'd0);
    check("miss_score", {22'd0, score_bin}, 32'd0);
    check("miss_data", data, 32'h0000_0000);

    // Reset in the middle of CONVERT acts immediately
    digit_sel = 2'd0;
    do_write(2'b00, 10'd456, 1'b1);
    check("load456_score", {22'd0, score_bin}, 32'd456);
    repeat (5) @(negedge clk);
    res = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_score", {22'd0, score_bin}, 32'd0);
    check("midrst_data", data, 32'h7555_5557);
    @(negedge clk);
    res = 1'b0;
    repeat (12) @(negedge clk);
    check("postrst_busy", {31'd0, busy}, 32'd0);
    check("postrst_data", data, 32'h7555_5557);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
